filter_ctrl_master: RTL

AXI4-Lite master sequencer that runs one image-filter job on the filter IP's control slave without a CPU. On a `start` pulse it:

- polls STATUS until the IP is idle;
- loads the 3x3 kernel into FILTER;
- writes CTRL=1 (start) and polls STATUS until done;
- writes CTRL=0 (stop) and reports completion.

It sits beside `imageFilterTop` and drives its `s_axi_control_*` port. It is the RTL counterpart of the control master the bench models with tasks.

---
 rtl/filter_ctrl_master_if.sv | 33 +++
 rtl/filter_ctrl_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/filter_ctrl_master_if.sv
// AXI4-Lite control bus between the filter job sequencer (master) and the
// filter IP control slave.
interface filter_ctrl_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/filter_ctrl_master.sv
// Runs one image-filter job over AXI4-Lite: wait idle, load kernel, start,
// wait done, stop. One transaction outstanding at a time.
module filter_ctrl_master #(
    parameter int AXI_CONTROL_DATA_WIDTH = 32,
    parameter int AXI_CONTROL_ADDR_WIDTH = 4,
    parameter int POLL_GAP               = 4,
    parameter int MAX_POLLS              = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [26:0]          filter_coeffs,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    filter_ctrl_master_if.master m_axi_control
);
    localparam int DW  = AXI_CONTROL_DATA_WIDTH;
    localparam int AW  = AXI_CONTROL_ADDR_WIDTH;
    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [GW-1:0]  GAP_LAST    = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [PCW-1:0] POLL_LIMIT  = PCW'(MAX_POLLS);
    localparam logic [AW-1:0]  ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0]  ADDR_STATUS = AW'(4);
    localparam logic [AW-1:0]  ADDR_FILTER = AW'(8);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL_IDLE, S_WR_FILTER, S_WR_START, S_POLL_DONE, S_WR_STOP, S_FINISH
    } state_t;

    // Every bus step walks REQ -> RESP -> EVAL; polls add GAP before the next REQ.
    typedef enum logic [1:0] {PH_REQ, PH_RESP, PH_EVAL, PH_GAP} phase_t;

    state_t          state_q, state_d, state_after;
    phase_t          phase_q, phase_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic            error_q, error_d;
    logic [26:0]     coeffs_q, coeffs_d;
    logic [DW-1:0]   rdata_q, rdata_d, status_target;
    logic [1:0]      resp_q, resp_d;
    logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            is_poll, is_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_REQ;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            error_q    <= 1'b0;
            coeffs_q   <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            error_q    <= error_d;
            coeffs_q   <= coeffs_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        error_d    = error_q;
        coeffs_d   = coeffs_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        is_poll  = (state_q == S_POLL_IDLE) || (state_q == S_POLL_DONE);
        is_write = (state_q == S_WR_FILTER) || (state_q == S_WR_START) || (state_q == S_WR_STOP);
        status_target = (state_q == S_POLL_DONE) ? DW'(2) : '0;

        case (state_q)
            S_POLL_IDLE: state_after = S_WR_FILTER;
            S_WR_FILTER: state_after = S_WR_START;
            S_WR_START:  state_after = S_POLL_DONE;
            S_POLL_DONE: state_after = S_WR_STOP;
            S_WR_STOP:   state_after = S_FINISH;
            default:     state_after = S_IDLE;
        endcase

        busy  = (state_q != S_IDLE);
        done  = (state_q == S_FINISH);
        error = error_q;

        m_axi_control.awaddr  = '0;
        m_axi_control.wdata   = '0;
        m_axi_control.araddr  = '0;
        m_axi_control.awvalid = 1'b0;
        m_axi_control.wvalid  = 1'b0;
        m_axi_control.bready  = 1'b0;
        m_axi_control.arvalid = 1'b0;
        m_axi_control.rready  = 1'b0;

        if (is_write) begin
            m_axi_control.awaddr = (state_q == S_WR_FILTER) ? ADDR_FILTER : ADDR_CTRL;
            if (state_q == S_WR_FILTER) m_axi_control.wdata = DW'(coeffs_q);
            else if (state_q == S_WR_START) m_axi_control.wdata = DW'(1);
        end
        if (is_poll) m_axi_control.araddr = ADDR_STATUS;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_POLL_IDLE;
                    phase_d    = PH_REQ;
                    coeffs_d   = filter_coeffs;
                    error_d    = 1'b0;
                    poll_cnt_d = '0;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default: begin
                unique case (phase_q)
                    PH_REQ: begin
                        if (is_write) begin
                            m_axi_control.awvalid = !aw_done_q;
                            m_axi_control.wvalid  = !w_done_q;
                            aw_done_d = aw_done_q | m_axi_control.awready;
                            w_done_d  = w_done_q | m_axi_control.wready;
                            if (aw_done_d && w_done_d) phase_d = PH_RESP;
                        end else begin
                            m_axi_control.arvalid = 1'b1;
                            if (m_axi_control.arready) phase_d = PH_RESP;
                        end
                    end
                    PH_RESP: begin
                        if (is_write) begin
                            m_axi_control.bready = 1'b1;
                            if (m_axi_control.bvalid) begin
                                resp_d  = m_axi_control.bresp;
                                phase_d = PH_EVAL;
                            end
                        end else begin
                            m_axi_control.rready = 1'b1;
                            if (m_axi_control.rvalid) begin
                                resp_d     = m_axi_control.rresp;
                                rdata_d    = m_axi_control.rdata;
                                poll_cnt_d = poll_cnt_q + 1'b1;
                                phase_d    = PH_EVAL;
                            end
                        end
                    end
                    PH_EVAL: begin
                        phase_d   = PH_REQ;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        if (resp_q != 2'b00) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else if (!is_poll || rdata_q == status_target) begin
                            state_d    = state_after;
                            poll_cnt_d = '0;
                        end else if (poll_cnt_q >= POLL_LIMIT) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else if (POLL_GAP > 0) begin
                            phase_d   = PH_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                    PH_GAP: begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                        if (gap_cnt_q == GAP_LAST) phase_d = PH_REQ;
                    end
                endcase
            end
        endcase
    end
endmodule
